mult18_arbiter: RTL and testbench
=================================

MULT18_ARBITER -- requirements
Module: mult18_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, range 2..8.
REQ-002 Parameter LAT, default 3: accept-to-result latency in cycles, fixed.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  NREQ  per-requester operation request.
REQ-006 req_a  input  18*NREQ  operand A, requester i at bits [18i+17:18i].
REQ-007 req_b  input  18*NREQ  operand B, same packing as req_a.
REQ-008 req_signed  input  NREQ  1 = two's-complement operands; 0 = unsigned.
REQ-009 req_ready  output  NREQ  one-hot grant; at most one bit high.
REQ-010 rsp_valid  output  NREQ  one-hot result strobe to the owning requester.
REQ-011 rsp_p  output  36  product, valid only when rsp_valid is nonzero.
REQ-012 ops_done  output  16  count of results delivered.

Function
REQ-013 The block SHALL time-share one 18x18 multiplier among NREQ requesters, accepting at most one operation per cycle.
REQ-014 Transfer occurs on requester i in a cycle when req_valid[i] and req_ready[i] are both high.
REQ-015 req_ready SHALL be a combinational function of req_valid and the round-robin pointer; requester i is granted if it is the first valid index at or after the pointer, wrapping modulo NREQ.
REQ-016 After a transfer from requester i, the pointer SHALL become (i+1) mod NREQ; with no transfer it holds.
REQ-017 When no req_valid bit is set, req_ready SHALL be all zeros.
REQ-018 Requesters hold req_valid and operands stable until accepted; the block does not depend on this for correctness of already-accepted operations.
REQ-019 An operation accepted in cycle t SHALL produce rsp_valid one-hot to its owner and rsp_p in cycle t+LAT, for exactly one cycle.
REQ-020 Throughput SHALL be one result per cycle with back-to-back accepts; no response backpressure exists.
REQ-021 Signed mode: rsp_p = sign-extended A * sign-extended B, 36-bit two's complement; unsigned mode: zero-extended product.
REQ-022 Owner index and signed flag SHALL travel in a LAT-deep shift pipeline alongside the operands.
REQ-023 ops_done SHALL increment by 1 in each cycle rsp_valid is nonzero and wrap from 0xFFFF to 0x0000.
REQ-024 With a single continuously valid requester, that requester SHALL be accepted every cycle.
REQ-025 With all requesters continuously valid, grants SHALL rotate 0,1,...,NREQ-1,0,... with no requester waiting more than NREQ-1 cycles.

Reset
REQ-026 While rst is high: req_ready=0, rsp_valid=0, rsp_p=0, ops_done=0, pointer=0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight operations; no rsp_valid for them after release.
REQ-028 First accept possible in the first rising edge with rst low.

Structure
REQ-029 Shared package holds MULT_W=18, PROD_W=36, default LAT, and the owner-tag width function clog2(NREQ).
REQ-030 One sub-module, rr_arbiter (pointer register plus masked priority encoder, one-hot output), is natural; the multiplier pipeline stays in the top module, inferable onto EG_PHY_MULT18 with input and output registers.

Verification
REQ-031 Requester 2 alone: A=0x00003, B=0x00005, unsigned, accept at cycle 10 -> rsp_valid=0b0100 at cycle 13, rsp_p=15.
REQ-032 Signed: A=0x3FFFF (-1), B=0x00002 -> rsp_p=0xFFFFFFFFE (-2); same operands unsigned -> rsp_p=0x7FFFE.
REQ-033 All 4 valid continuously for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; results in same order, LAT later.
REQ-034 Requesters 1 and 3 valid, pointer=2 -> grant 3 first, then 1.
REQ-035 Three accepts in flight, rst pulsed for one cycle -> no rsp_valid afterwards, ops_done=0.
REQ-036 65537 results delivered -> ops_done=1 (wrap).

Source files
------------

// File: rtl/mult18_arbiter_pkg.sv
// rtl/mult18_arbiter_pkg.sv - shared widths, default latency and tag-width helper
package mult18_arbiter_pkg;

  localparam int MULT_W  = 18;
  localparam int PROD_W  = 36;
  localparam int DEF_LAT = 3;

  // Bits needed to hold an index in 0..n-1 (minimum 1).
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mult18_arbiter_rr_arbiter.sv
// rtl/mult18_arbiter_rr_arbiter.sv - round-robin pointer plus masked priority encoder
module rr_arbiter
  import mult18_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx
);

  logic [IW-1:0] ptr;

  // Walk offsets from farthest to nearest so the first valid index at or after ptr wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    if (!rst) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        for (int i = 0; i < NREQ; i++) begin
          if (req[i] && (((int'(ptr) + k) % NREQ) == i)) begin
            grant     = '0;
            grant[i]  = 1'b1;
            grant_idx = IW'(i);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (|grant) begin
      ptr <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/mult18_arbiter.sv
// rtl/mult18_arbiter.sv - one 18x18 multiplier time-shared round-robin among NREQ requesters
module mult18_arbiter
  import mult18_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = DEF_LAT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [MULT_W*NREQ-1:0]   req_a,
  input  logic [MULT_W*NREQ-1:0]   req_b,
  input  logic [NREQ-1:0]          req_signed,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [PROD_W-1:0]        rsp_p,
  output logic [15:0]              ops_done
);

  localparam int IW = clog2(NREQ);

  logic [IW-1:0]     gidx;
  logic [MULT_W-1:0] a_sel, b_sel, a_r, b_r;
  logic              s_sel, s_r;
  logic [PROD_W-1:0] ax, bx;
  logic [PROD_W-1:0] p_pipe [LAT-1];
  logic              v_pipe [LAT];
  logic [IW-1:0]     own_pipe [LAT];

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .grant     (req_ready),
    .grant_idx (gidx)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    s_sel = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        a_sel = req_a[MULT_W*i +: MULT_W];
        b_sel = req_b[MULT_W*i +: MULT_W];
        s_sel = req_signed[i];
      end
    end
  end

  // Data path carries no reset so it maps onto the hard multiplier's input/output registers.
  always_ff @(posedge clk) begin
    a_r <= a_sel;
    b_r <= b_sel;
    s_r <= s_sel;
  end

  // Low 36 bits of the extended product are correct for both signed and unsigned operands.
  always_comb begin
    ax = s_r ? {{(PROD_W-MULT_W){a_r[MULT_W-1]}}, a_r} : {{(PROD_W-MULT_W){1'b0}}, a_r};
    bx = s_r ? {{(PROD_W-MULT_W){b_r[MULT_W-1]}}, b_r} : {{(PROD_W-MULT_W){1'b0}}, b_r};
  end

  always_ff @(posedge clk) begin
    p_pipe[0] <= ax * bx;
    for (int k = 1; k < LAT - 1; k++) p_pipe[k] <= p_pipe[k-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) begin
        v_pipe[k]   <= 1'b0;
        own_pipe[k] <= '0;
      end
      ops_done <= '0;
    end else begin
      v_pipe[0]   <= |req_ready;
      own_pipe[0] <= gidx;
      for (int k = 1; k < LAT; k++) begin
        v_pipe[k]   <= v_pipe[k-1];
        own_pipe[k] <= own_pipe[k-1];
      end
      if (v_pipe[LAT-1]) ops_done <= ops_done + 16'd1;
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (v_pipe[LAT-1] && own_pipe[LAT-1] == IW'(i)) rsp_valid[i] = 1'b1;
    end
    rsp_p = v_pipe[LAT-1] ? p_pipe[LAT-2] : '0;
  end

endmodule

// File: tb/tb_mult18_arbiter.sv
// tb/tb_mult18_arbiter.sv - scoreboard bench for mult18_arbiter
module tb_mult18_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 3;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [18*NREQ-1:0]   req_a;
  logic [18*NREQ-1:0]   req_b;
  logic [NREQ-1:0]      req_signed;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      rsp_valid;
  logic [35:0]          rsp_p;
  logic [15:0]          ops_done;

  mult18_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_signed (req_signed),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_p      (rsp_p),
    .ops_done   (ops_done)
  );

  typedef struct {
    int          due;
    int          owner;
    logic [35:0] p;
  } exp_t;

  exp_t        sq[$];
  int          gq[$];
  logic [35:0] exp_tab [NREQ];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          mptr = 0;
  int          mops = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [35:0] model_p(input logic [17:0] a, input logic [17:0] b, input logic s);
    longint sa, sb;
    sa = s ? longint'($signed(a)) : longint'(a);
    sb = s ? longint'($signed(b)) : longint'(b);
    return 36'(sa * sb);
  endfunction

  task automatic drive(input int i, input logic [17:0] a, input logic [17:0] b, input logic s,
                       input logic [35:0] p);
    req_a[18*i +: 18] = a;
    req_b[18*i +: 18] = b;
    req_signed[i]     = s;
    exp_tab[i]        = p;
  endtask

  task automatic drive_rand(input int i);
    logic [17:0] a, b;
    logic        s;
    a = 18'($urandom);
    b = 18'($urandom);
    s = 1'($urandom);
    drive(i, a, b, s, model_p(a, b, s));
  endtask

  // Reference: compare outputs against the queue head, then predict this cycle's grant.
  task automatic monitor();
    logic [NREQ-1:0] eg;
    logic [NREQ-1:0] oh;
    int              g;
    exp_t            h;
    if (rst) begin
      sq.delete();
      mptr = 0;
      mops = 0;
      check("rst_ready", 64'(req_ready), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_p", 64'(rsp_p), 64'd0);
      check("rst_ops_done", 64'(ops_done), 64'd0);
    end else begin
      check("ops_done", 64'(ops_done), 64'(mops));
      if (sq.size() > 0 && sq[0].due == cyc) begin
        h  = sq.pop_front();
        oh = NREQ'(1) << h.owner;
        check("rsp_valid", 64'(rsp_valid), 64'(oh));
        check("rsp_p", 64'(rsp_p), 64'(h.p));
        mops = (mops + 1) % 65536;
      end else begin
        check("rsp_idle", 64'(rsp_valid), 64'd0);
      end
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && req_valid[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
      end
      eg = (g >= 0) ? (NREQ'(1) << g) : '0;
      check("req_ready", 64'(req_ready), 64'(eg));
      if (g >= 0) begin
        sq.push_back('{cyc + LAT, g, exp_tab[g]});
        gq.push_back(g);
        mptr = (g + 1) % NREQ;
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    monitor();
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 20 && sq.size() > 0; n++) step();
    check("drain", 64'(sq.size()), 64'd0);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '1;
    req_a      = '0;
    req_b      = '0;
    req_signed = '0;
    for (int i = 0; i < NREQ; i++) exp_tab[i] = '0;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < NREQ; i++) drive_rand(i);
      step();
    end

    // All requesters valid straight out of reset: strict rotation.
    gq.delete();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NREQ; i++) drive_rand(i);
      step();
    end
    req_valid = '0;
    check("rot_count", 64'(gq.size()), 64'd8);
    for (int k = 0; k < 8 && k < gq.size(); k++) check("rot_order", 64'(gq[k]), 64'(k % NREQ));
    wait_drain();

    // Requester 2 alone, unsigned 3*5.
    drive(2, 18'h00003, 18'h00005, 1'b0, 36'd15);
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    wait_drain();

    // -1 * 2 signed, then same bits unsigned.
    drive(0, 18'h3FFFF, 18'h00002, 1'b1, 36'hFFFFFFFFE);
    req_valid = 4'b0001;
    step();
    drive(0, 18'h3FFFF, 18'h00002, 1'b0, 36'h00007FFFE);
    step();
    req_valid = '0;
    wait_drain();

    // Move pointer to 2, then contend 1 vs 3.
    drive_rand(1);
    req_valid = 4'b0010;
    step();
    gq.delete();
    drive_rand(1);
    drive_rand(3);
    req_valid = 4'b1010;
    step();
    req_valid[3] = 1'b0;
    step();
    req_valid = '0;
    check("ptr2_count", 64'(gq.size()), 64'd2);
    if (gq.size() >= 2) begin
      check("ptr2_first", 64'(gq[0]), 64'd3);
      check("ptr2_second", 64'(gq[1]), 64'd1);
    end
    wait_drain();

    // Random contention.
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NREQ; i++) drive_rand(i);
      req_valid = NREQ'($urandom);
      step();
    end
    req_valid = '0;
    wait_drain();

    // Three accepts in flight, then a one-cycle reset.
    req_valid = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      drive_rand(0);
      step();
    end
    req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) step();
    check("flush_ops_done", 64'(ops_done), 64'd0);

    // Single requester every cycle for 65537 results: counter wraps to 1.
    req_valid = 4'b0001;
    for (int c = 0; c < 65537; c++) begin
      drive_rand(0);
      step();
    end
    req_valid = '0;
    wait_drain();
    step();
    check("ops_wrap", 64'(ops_done), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
